// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional signed mode is selected with BIN_TO_BCD_SIGNED_INPUT_EN.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/response bundle for bin_to_bcd_seq.
// Handshake: a request is accepted on a rising edge where i_valid and o_ready are both high;
// o_valid is a one-cycle pulse marking that o_bcd/o_neg were just updated (no back-pressure).
interface bin_to_bcd_seq_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  i_valid;
    logic                  o_ready;
    logic [WIDTH-1:0]      i_bin;
    logic                  o_valid;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_neg;

    modport master (
        output i_valid,
        output i_bin,
        input  o_ready,
        input  o_valid,
        input  o_bcd,
        input  o_neg
    );

    modport slave (
        input  i_valid,
        input  i_bin,
        output o_ready,
        output o_valid,
        output o_bcd,
        output o_neg
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the next left shift.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t i_digit,
    output bcd_digit_t o_digit
);

    assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one shift per clock.
// Define BIN_TO_BCD_SIGNED_INPUT_EN to treat i_bin as two's complement and report the sign on o_neg.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    bin_to_bcd_seq_if.slave  bus,
    output bcd_state_t       o_dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);

    bcd_state_t          state_q;
    logic                ready_q;
    logic                valid_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BCD_W-1:0]    scratch_q;
    logic [WIDTH-1:0]    shift_q;

    logic [BCD_W-1:0]       adj;
    logic [BCD_W+WIDTH-1:0] shifted;
    logic [BCD_W-1:0]       scratch_d;
    logic [WIDTH-1:0]       shift_d;
    logic [WIDTH-1:0]       operand_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (scratch_q[4*g +: 4]),
            .o_digit (adj[4*g +: 4])
        );
    end

    // The adjusted scratch MSB is always 0 when DIGITS is large enough, so the shift drops nothing.
    always_comb begin
        shifted   = {adj, shift_q} << 1;
        scratch_d = shifted[BCD_W+WIDTH-1:WIDTH];
        shift_d   = shifted[WIDTH-1:0];
    end

`ifdef BIN_TO_BCD_SIGNED_INPUT_EN
    logic sign_d;
    logic sign_q;
    logic neg_q;

    // |i_bin| fits in WIDTH unsigned bits, including the most negative value.
    assign sign_d    = bus.i_bin[WIDTH-1];
    assign operand_d = sign_d ? (~bus.i_bin + WIDTH'(1)) : bus.i_bin;
    assign bus.o_neg = neg_q;
`else
    assign operand_d = bus.i_bin;
    assign bus.o_neg = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            scratch_q <= '0;
            shift_q   <= '0;
`ifdef BIN_TO_BCD_SIGNED_INPUT_EN
            sign_q    <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid && ready_q) begin
                        shift_q   <= operand_d;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= SHIFT;
`ifdef BIN_TO_BCD_SIGNED_INPUT_EN
                        sign_q    <= sign_d;
`endif
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= shift_d;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        bcd_q   <= scratch_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
`ifdef BIN_TO_BCD_SIGNED_INPUT_EN
                        neg_q   <= sign_q;
`endif
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_bcd   = bcd_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq; covers both unsigned and BIN_TO_BCD_SIGNED_INPUT_EN builds.
module tb_bin_to_bcd_seq;
    import bcd_pkg::*;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int EXP_W  = BCD_W + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    bcd_state_t dbg_state;

    bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int unsigned      acc_q[$];
    logic [EXP_W-1:0] hold_exp = '0;
    logic             prev_valid = 1'b0;
    int               errors = 0;
    int               checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: decimal digits by repeated division; sign-magnitude in signed mode.
    function automatic logic [EXP_W-1:0] model(input logic [WIDTH-1:0] b);
        int unsigned      mag;
        logic             neg;
        logic [BCD_W-1:0] r;
        mag = b;
        neg = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_INPUT_EN
        if (b[WIDTH-1]) begin
            neg = 1'b1;
            mag = (32'd1 << WIDTH) - b;
        end
`endif
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {neg, r};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [EXP_W-1:0] e;
        int unsigned      a;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                hold_exp   = '0;
                prev_valid = 1'b0;
            end else begin
                if (bus.o_valid) begin
                    chk("valid_pulse", 64'(prev_valid), 64'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 64'(bus.o_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        chk("result", 64'({bus.o_neg, bus.o_bcd}), 64'(e));
                        chk("latency", 64'(cyc - a), 64'(WIDTH));
                        hold_exp = e;
                    end
                    for (int i = 0; i < DIGITS; i++) begin
                        checks++;
                        if (bus.o_bcd[4*i +: 4] > 4'd9) begin
                            errors++;
                            $display("FAIL nibble_le9: digit %0d got %0h expected <=9", i, bus.o_bcd[4*i +: 4]);
                        end
                    end
                end else begin
                    chk("hold", 64'({bus.o_neg, bus.o_bcd}), 64'(hold_exp));
                end
                prev_valid = bus.o_valid;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [WIDTH-1:0] v, input logic [EXP_W-1:0] e,
                        input bit keep_valid, output int unsigned acc_edge);
        bit got;
        got = 1'b0;
        acc_edge = 0;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b1;
        bus.i_bin   = v;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.o_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1 within 200 cycles");
            bus.i_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        acc_edge = cyc + 1;
        acc_q.push_back(acc_edge);
        @(posedge clk);
        #1;
        if (!keep_valid) bus.i_valid = 1'b0;
        bus.i_bin = WIDTH'($urandom);
        if (keep_valid) begin
            repeat (8) @(posedge clk);
            #1;
            bus.i_bin = WIDTH'($urandom);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && bus.o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned      a0, a1, a2, a3;
        logic [WIDTH-1:0] v;
        bus.i_valid = 1'b0;
        bus.i_bin   = '0;
        rst         = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_bcd",   64'(bus.o_bcd),   64'd0);
        chk("rst_neg",   64'(bus.o_neg),   64'd0);
        chk("rst_state", 64'(dbg_state),   64'(IDLE));

        send(16'h0000, {1'b0, 20'h00000}, 1'b0, a0);
`ifdef BIN_TO_BCD_SIGNED_INPUT_EN
        send(16'hFFFF, {1'b1, 20'h00001}, 1'b0, a0);
        send(16'h8000, {1'b1, 20'h32768}, 1'b0, a0);
        send(16'h7FFF, {1'b0, 20'h32767}, 1'b0, a0);
        send(16'hFE01, {1'b1, 20'h00511}, 1'b0, a0);
`else
        send(16'hFE01, {1'b0, 20'h65025}, 1'b0, a0);
        send(16'hFFFF, {1'b0, 20'h65535}, 1'b0, a0);
        send(16'h7FFF, {1'b0, 20'h32767}, 1'b0, a0);
`endif
        wait_idle();

        // Abandon a conversion with a reset pulse landing on its 8th shift.
        send(16'h1234, model(16'h1234), 1'b0, a0);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(bus.o_ready), 64'd1);
        chk("midrst_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_bcd",   64'(bus.o_bcd),   64'd0);
        chk("midrst_state", 64'(dbg_state),   64'(IDLE));
        repeat (30) @(negedge clk);
        send(16'h0064, {1'b0, 20'h00100}, 1'b0, a0);
        wait_idle();

        // i_valid held high back to back, operand scrambled mid-conversion.
        send(16'h0001, {1'b0, 20'h00001}, 1'b1, a0);
        send(16'h0002, {1'b0, 20'h00002}, 1'b1, a1);
        send(16'h0001, {1'b0, 20'h00001}, 1'b1, a2);
        send(16'h0002, {1'b0, 20'h00002}, 1'b0, a3);
        chk("spacing_1", 64'(a1 - a0), 64'(WIDTH + 2));
        chk("spacing_2", 64'(a2 - a1), 64'(WIDTH + 2));
        chk("spacing_3", 64'(a3 - a2), 64'(WIDTH + 2));
        wait_idle();

        for (int n = 0; n < 1000; n++) begin
            v = WIDTH'($urandom);
            send(v, model(v), 1'b0, a0);
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
